// File: rtl/irrig_pkg.sv
// Shared irrigation-controller definitions: edge-detection modes and the
// helper that decides whether a newly accepted level counts as an event.
package irrig_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  localparam int DEFAULT_N_CH            = 4;
  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  // Bit 0 of the mode arms rising events, bit 1 arms falling events.
  function automatic logic edgeSelected(input logic [1:0] mode, input logic newLevel);
    return (newLevel & mode[0]) | (~newLevel & mode[1]);
  endfunction

endpackage

// File: rtl/level_to_pulse_array_if.sv
// Bundle of the sensor-side levels/controls and the per-channel event outputs
// exchanged between the level-to-pulse array and its user.
interface level_to_pulse_array_if #(
  parameter int N_CH = 4
) ();

  logic [N_CH-1:0]   level_in;
  logic [2*N_CH-1:0] edge_mode;
  logic [N_CH-1:0]   clr;
  logic [N_CH-1:0]   level_db;
  logic [N_CH-1:0]   pulse;
  logic              pulse_any;
  logic [N_CH-1:0]   evt_flag;

  modport master (
    output level_in,
    output edge_mode,
    output clr,
    input  level_db,
    input  pulse,
    input  pulse_any,
    input  evt_flag
  );

  modport slave (
    input  level_in,
    input  edge_mode,
    input  clr,
    output level_db,
    output pulse,
    output pulse_any,
    output evt_flag
  );

endinterface

// File: rtl/lp_channel.sv
// One sensor channel: synchroniser chain, debounce counter, edge-selected
// single-cycle pulse and a sticky event flag with explicit clear.
module lp_channel
  import irrig_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       level_i,
  input  logic [1:0] mode_i,
  input  logic       clr_i,
  output logic       level_o,
  output logic       pulse_o,
  output logic       flag_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q, level_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   flag_q, flag_d;
  logic                   syncLevel;
  logic                   accept;

  assign syncLevel = sync_q[SYNC_STAGES-1];

  // The counter measures how long the synchronised level has disagreed with
  // the accepted one; any agreement restarts it, so glitches never accept.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    accept  = 1'b0;
    if (syncLevel != level_q) begin
      if (cnt_q == CNT_LAST) begin
        accept  = 1'b1;
        level_d = syncLevel;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pulse_d = accept & edgeSelected(mode_i, syncLevel);
    flag_d  = (flag_q & ~clr_i) | pulse_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], level_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      flag_q  <= flag_d;
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;
  assign flag_o  = flag_q;

endmodule

// File: rtl/level_to_pulse_array.sv
// Multi-channel level-to-pulse converter between raw sensor pins and the
// irrigation control FSM; channels are independent apart from pulse_any.
module level_to_pulse_array #(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                    clk,
  input logic                    rst,
  level_to_pulse_array_if.slave  bus
);

  logic [N_CH-1:0] levelVec;
  logic [N_CH-1:0] pulseVec;
  logic [N_CH-1:0] flagVec;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    lp_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_channel (
      .clk     (clk),
      .rst     (rst),
      .level_i (bus.level_in[i]),
      .mode_i  (bus.edge_mode[2*i +: 2]),
      .clr_i   (bus.clr[i]),
      .level_o (levelVec[i]),
      .pulse_o (pulseVec[i]),
      .flag_o  (flagVec[i])
    );
  end

  // pulse_any is a pure reduction of registered pulses, so it adds no latency.
  assign bus.level_db  = levelVec;
  assign bus.pulse     = pulseVec;
  assign bus.pulse_any = |pulseVec;
  assign bus.evt_flag  = flagVec;

endmodule

// File: tb/tb_level_to_pulse_array.sv
// Scoreboard bench: the driver predicts each cycle's outputs from a window
// model of the debounce rules; an independent monitor compares them.
module tb_level_to_pulse_array;
  import irrig_pkg::*;

  localparam int N_CH = 4;
  localparam int SYNC_STAGES = 2;
  localparam int DEBOUNCE_CYCLES = 4;

  typedef struct packed {
    logic [N_CH-1:0] levelDb;
    logic [N_CH-1:0] pulse;
    logic            pulseAny;
    logic [N_CH-1:0] evtFlag;
  } expect_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  level_to_pulse_array_if #(.N_CH(N_CH)) bus ();

  level_to_pulse_array #(
    .N_CH            (N_CH),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  expect_t expQ[$];
  int nVectors = 0;
  int nMiscompares = 0;

  logic [N_CH-1:0]   curLvl  = '0;
  logic [2*N_CH-1:0] curMode = '0;
  logic [N_CH-1:0]   curClr  = '0;

  // Reference state: raw samples still in flight through the synchroniser,
  // the recent synchronised samples, and the accepted level/flag.
  bit rawQ [N_CH][$];
  bit sWin [N_CH][$];
  bit modelD [N_CH];
  bit modelFlag [N_CH];

  task automatic resetModel();
    for (int ch = 0; ch < N_CH; ch++) begin
      rawQ[ch].delete();
      for (int k = 0; k < SYNC_STAGES; k++) rawQ[ch].push_back(1'b0);
      sWin[ch].delete();
      modelD[ch] = 1'b0;
      modelFlag[ch] = 1'b0;
    end
  endtask

  // A level is accepted once the last DEBOUNCE_CYCLES synchronised samples
  // all disagree with the currently accepted level.
  task automatic modelStep(input bit rstV, output expect_t e);
    bit s, allDiff, fire;
    edge_mode_e m;
    e = '0;
    if (rstV) begin
      resetModel();
      return;
    end
    for (int ch = 0; ch < N_CH; ch++) begin
      s = rawQ[ch].pop_front();
      rawQ[ch].push_back(curLvl[ch]);
      sWin[ch].push_back(s);
      if (sWin[ch].size() > DEBOUNCE_CYCLES) void'(sWin[ch].pop_front());
      fire = 1'b0;
      if (sWin[ch].size() == DEBOUNCE_CYCLES) begin
        allDiff = 1'b1;
        foreach (sWin[ch][k]) if (sWin[ch][k] == modelD[ch]) allDiff = 1'b0;
        if (allDiff) begin
          modelD[ch] = s;
          sWin[ch].delete();
          m = edge_mode_e'(curMode[2*ch +: 2]);
          fire = (m == EDGE_BOTH) || (m == EDGE_RISE && s) || (m == EDGE_FALL && !s);
        end
      end
      if (fire) modelFlag[ch] = 1'b1;
      else if (curClr[ch]) modelFlag[ch] = 1'b0;
      e.levelDb[ch] = modelD[ch];
      e.pulse[ch]   = fire;
      e.evtFlag[ch] = modelFlag[ch];
    end
    e.pulseAny = |e.pulse;
  endtask

  task automatic applyStimulus(input bit rstV);
    expect_t e;
    @(negedge clk);
    bus.level_in  = curLvl;
    bus.edge_mode = curMode;
    bus.clr       = curClr;
    rst           = rstV;
    modelStep(rstV, e);
    expQ.push_back(e);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0);
  endtask

  task automatic checkOutput(input expect_t e);
    nVectors++;
    if (bus.level_db !== e.levelDb || bus.pulse !== e.pulse ||
        bus.pulse_any !== e.pulseAny || bus.evt_flag !== e.evtFlag) begin
      nMiscompares++;
      $display("[TB] FAIL outputs @%0t: level_db=%b exp %b, pulse=%b exp %b, pulse_any=%b exp %b, evt_flag=%b exp %b",
               $time, bus.level_db, e.levelDb, bus.pulse, e.pulse,
               bus.pulse_any, e.pulseAny, bus.evt_flag, e.evtFlag);
    end
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : driver
    bus.level_in  = '0;
    bus.edge_mode = '0;
    bus.clr       = '0;
    resetModel();

    for (int i = 0; i < 3; i++) applyStimulus(1'b1);
    cycles(20);

    // ch0 rising edge, then a fall that must stay silent
    curMode[1:0] = EDGE_RISE;
    curLvl[0] = 1'b1; cycles(12);
    curLvl[0] = 1'b0; cycles(12);

    // ch1 short glitch, then a long high giving two pulses
    curMode[3:2] = EDGE_BOTH;
    curLvl[1] = 1'b1; cycles(3);
    curLvl[1] = 1'b0; cycles(10);
    curLvl[1] = 1'b1; cycles(12);
    curLvl[1] = 1'b0; cycles(14);

    // ch2 clear colliding with a new pulse, then clear alone
    curMode[5:4] = EDGE_BOTH;
    curLvl[2] = 1'b1; cycles(10);
    curLvl[2] = 1'b0; cycles(5);
    curClr[2] = 1'b1; cycles(2);
    curClr[2] = 1'b0; cycles(4);

    // ch3 off-mode tracking, then mode switch during a falling debounce
    curMode[7:6] = EDGE_OFF;
    for (int p = 0; p < 3; p++) begin
      curLvl[3] = 1'b1; cycles(10);
      curLvl[3] = 1'b0; cycles(10);
    end
    curLvl[3] = 1'b1; cycles(10);
    curLvl[3] = 1'b0; cycles(3);
    curMode[7:6] = EDGE_FALL; cycles(10);

    // reset in the middle of a ch0 debounce with the level held high
    curLvl[0] = 1'b1; cycles(2);
    applyStimulus(1'b1);
    cycles(12);

    for (int i = 0; i < 2000; i++) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        if ($urandom_range(0, 7) == 0) curLvl[ch] = ~curLvl[ch];
        if ($urandom_range(0, 39) == 0) curMode[2*ch +: 2] = 2'($urandom_range(0, 3));
        curClr[ch] = ($urandom_range(0, 5) == 0);
      end
      applyStimulus($urandom_range(0, 399) == 0);
    end

    for (int i = 0; i < 5 && expQ.size() != 0; i++) @(negedge clk);
    if (expQ.size() != 0) begin
      nMiscompares++;
      $display("[TB] FAIL drain: %0d expected vectors never compared, required 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
